imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core.
- Accepts a byte stream (from a UART receiver or test host) carrying a program image and assembles it into little-endian 32-bit words.
- Writes those words into the instruction memory write port.
- Holds the core in reset until the image is complete, then releases it. A reload request re-enters loading at any time after a load finishes.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- DEPTH, 256, max words accepted (must be ≤ 2^ADDR_W).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte this cycle
- load_req  input  1  request a reload; honoured only in RUN or ERR
- imem_we  output  1  instruction-memory write strobe (one cycle per word)
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  word to write
- cpu_rstn  output  1  active-low reset to core; 0 while loading
- done  output  1  image loaded, core running
- err  output  1  header invalid
- word_cnt  output  16  words written so far in the current load

Behaviour:
- Reset (rstn=0, asynchronous) sets all outputs to 0: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rstn=0, done=0, err=0, word_cnt=0. State becomes HDR_LO.
- Byte accept: a byte is accepted on a rising clk edge where in_valid=1 and in_ready=1. in_valid may be held without acceptance; no data is lost or duplicated.
- Image format: header N (16-bit, little-endian: low byte first), then 4·N payload bytes. Each word arrives least-significant byte first; byte k of a word lands in bits [8k+7:8k].
- States:
  - HDR_LO: in_ready=1. On accept, latch N[7:0] and go to HDR_HI.
  - HDR_HI: in_ready=1. On accept, latch N[15:8] and check N.
    - N=0 or N>DEPTH: go to ERR.
    - Otherwise: go to LOAD and clear the byte and word counters.
  - LOAD: in_ready=1 and one byte is accepted per cycle at full rate. On the 4th byte of a word accepted at edge T:
    - at T+1: imem_we=1, imem_addr = word index, imem_wdata = assembled word, word_cnt increments.
    - in_ready stays 1 during the write cycle.
    - On the final byte of word N−1, state moves to FLUSH at the same edge; in_ready=0 from that cycle on.
  - FLUSH: one cycle; the last word's imem_we is asserted here. Next state is RUN.
  - RUN: cpu_rstn=1, done=1, in_ready=0. Timing: final byte accepted at T → last write at T+1 → cpu_rstn=1 and done=1 at T+2.
    - load_req=1 at an edge → HDR_LO with cpu_rstn=0, done=0, word_cnt=0 from the next cycle. Instruction memory contents are not cleared.
  - ERR: err=1, cpu_rstn=0, in_ready=0.
    - Sticky until load_req=1 → HDR_LO with err cleared.
    - Also cleared by rstn.
- Outside RUN/ERR: load_req is ignored in HDR_LO, HDR_HI, LOAD and FLUSH.
- imem_we: high for exactly one cycle per word, never in any other state. imem_addr holds its last value when imem_we=0.
- Counter widths: imem_addr is the word index truncated to ADDR_W. word_cnt never exceeds N.
- Stalls: bytes may arrive with arbitrary gaps (in_valid low); the partial word is retained across gaps.
- Reset mid-load: asynchronous rstn clears state immediately. Partially written memory is not rolled back; the core stays in reset (cpu_rstn=0) until a complete reload.

Test Plan:
- Nominal load: N=2 (bytes 02,00), payload 13,05,50,00, 93,05,A0,00 sent back-to-back → writes addr0=0x00500513 and addr1=0x00A00593 on consecutive-word cycles; cpu_rstn and done rise exactly 2 cycles after the last byte; word_cnt=2.
- Gapped stream: same image with in_valid low for 3 cycles between every byte → identical memory writes; no extra imem_we pulses.
- Bad header: send 00,00 → err=1, in_ready=0, cpu_rstn=0. Send 01,01 (N=257 > DEPTH=256) → err=1. Pulse load_req → err=0 and loader back in HDR_LO.
- Reload: after a successful load, pulse load_req in RUN → cpu_rstn=0, done=0, word_cnt=0 next cycle. Load N=1, word 0xDEADBEEF → addr0 overwritten; done returns.
- Ignored request: assert load_req throughout LOAD → no effect; the load completes normally.
- Async reset mid-word: assert rstn=0 after 2 payload bytes of word 1 → all outputs 0 immediately. After release, a full N=1 load writes only addr0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream (16-bit word count header,
// then payload words) into instruction memory and releases the core when done.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_LOAD   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  n_lo_r;
  logic [15:0] n_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] part_r;

  logic        accept_s;
  logic [15:0] hdr_n_s;
  logic        hdr_bad_s;
  logic        word_done_s;
  logic        last_word_s;
  logic        reload_s;

  assign accept_s    = in_valid & in_ready;
  assign hdr_n_s     = {in_data, n_lo_r};
  assign hdr_bad_s   = (hdr_n_s == 16'd0) || ({1'b0, hdr_n_s} > DEPTH_L);
  assign word_done_s = accept_s && (state_r == ST_LOAD) && (byte_cnt_r == 2'd3);
  assign last_word_s = word_done_s && (word_cnt == (n_r - 16'd1));
  assign reload_s    = load_req && ((state_r == ST_RUN) || (state_r == ST_ERR));

  // Next-state logic for the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR_LO: begin
        if (accept_s) state_nxt_s = ST_HDR_HI;
        else          state_nxt_s = state_r;
      end
      ST_HDR_HI: begin
        if (accept_s) begin
          if (hdr_bad_s) state_nxt_s = ST_ERR;
          else           state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (last_word_s) state_nxt_s = ST_FLUSH;
        else             state_nxt_s = state_r;
      end
      ST_FLUSH: state_nxt_s = ST_RUN;
      ST_RUN, ST_ERR: begin
        if (load_req) state_nxt_s = ST_HDR_LO;
        else          state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_HDR_LO;
    endcase
  end

  // State register and state-decoded status outputs, registered from next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_HDR_LO;
      in_ready <= 1'b0;
      cpu_rstn <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      in_ready <= (state_nxt_s == ST_HDR_LO) || (state_nxt_s == ST_HDR_HI) ||
                  (state_nxt_s == ST_LOAD);
      cpu_rstn <= (state_nxt_s == ST_RUN);
      done     <= (state_nxt_s == ST_RUN);
      err      <= (state_nxt_s == ST_ERR);
    end
  end

  // Header capture and byte assembly; the partial word survives input gaps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_lo_r     <= 8'd0;
      n_r        <= 16'd0;
      byte_cnt_r <= 2'd0;
      part_r     <= 24'd0;
    end else begin
      if (accept_s && (state_r == ST_HDR_LO)) begin
        n_lo_r <= in_data;
      end
      if (accept_s && (state_r == ST_HDR_HI)) begin
        n_r        <= hdr_n_s;
        byte_cnt_r <= 2'd0;
      end else if (accept_s && (state_r == ST_LOAD)) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        part_r     <= {in_data, part_r[23:8]};
      end
    end
  end

  // Memory write port and word counter; imem_addr/imem_wdata hold between writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_cnt   <= 16'd0;
    end else begin
      imem_we <= word_done_s;
      if (word_done_s) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= {in_data, part_r};
        word_cnt   <= word_cnt + 16'd1;
      end else if (reload_s || (accept_s && (state_r == ST_HDR_HI))) begin
        word_cnt <= 16'd0;
      end
    end
  end

endmodule
